decode_pipe: RTL

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/rv_decoder.sv | 82 ++++++++
 rtl/decode_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared opcodes, ALU control codes and decoded-entry layout
package decode_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_IN     = 7'b0000000;
  localparam logic [6:0] OP_OUT    = 7'b0000001;
  typedef enum logic [4:0] {
    ALU_AND = 5'd0, ALU_OR = 5'd1, ALU_ADD = 5'd2, ALU_XOR = 5'd3,
    ALU_SLL = 5'd4, ALU_SRL = 5'd5, ALU_SUB = 5'd6, ALU_LT = 5'd7,
    ALU_GE = 5'd8, ALU_CHOOSEB = 5'd10, ALU_EQ = 5'd11, ALU_NE = 5'd12,
    ALU_LTU = 5'd13, ALU_GEU = 5'd14, ALU_SRA = 5'd15, ALU_MUL = 5'd16,
    ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19, ALU_DIV = 5'd20,
    ALU_DIVU = 5'd21, ALU_REM = 5'd22, ALU_REMU = 5'd23, ALU_ZERO = 5'd31
  } alu_ctl_e;
  typedef struct packed {
    logic branch_uc, branch_c, branch_rel, mem_read, mem_write, alu_pc, alu_src, reg_write;
    logic data_out, data_in, readf1, readf2, writef, use_fpu, use_muldiv, illegal;
  } flags_t;
  typedef struct packed {
    logic [31:0] imm;
    alu_ctl_e alu_ctl;
    logic [4:0] rs1, rs2, rd;
    flags_t f;
  } bundle_t;
  function automatic alu_ctl_e alu_f3(input logic [2:0] f3);
    return f3 == 3'd0 ? ALU_ADD : f3 == 3'd1 ? ALU_SLL : f3 == 3'd2 ? ALU_LT :
           f3 == 3'd3 ? ALU_LTU : f3 == 3'd4 ? ALU_XOR : f3 == 3'd5 ? ALU_SRL :
           f3 == 3'd6 ? ALU_OR : ALU_AND;
  endfunction
  function automatic alu_ctl_e br_f3(input logic [2:0] f3);
    return f3 == 3'd0 ? ALU_EQ : f3 == 3'd1 ? ALU_NE : f3 == 3'd4 ? ALU_LT :
           f3 == 3'd5 ? ALU_GE : f3 == 3'd6 ? ALU_LTU : f3 == 3'd7 ? ALU_GEU : ALU_ZERO;
  endfunction
endpackage

// File: rtl/rv_decoder.sv
// rv_decoder: combinational RV32I(+M, +F subset) instruction to decoded bundle
module rv_decoder import decode_pkg::*; #(
  parameter bit EN_FPU = 1,
  parameter bit EN_MULDIV = 0
) (
  input logic [31:0] instr,
  output bundle_t dec
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic ill, rw;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  always_comb begin
    dec = '0;
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd = instr[11:7];
    dec.alu_ctl = ALU_ADD;
    dec.f.branch_rel = 1'b1;
    dec.f.alu_src = 1'b1;
    ill = 1'b0;
    rw = 1'b0;
    case (op)
      OP_LUI: begin dec.imm = imm_u; rw = 1'b1; end
      OP_AUIPC: begin dec.imm = imm_u; dec.f.alu_pc = 1'b1; rw = 1'b1; end
      OP_JAL: begin dec.imm = imm_j; dec.alu_ctl = ALU_CHOOSEB; dec.f.branch_uc = 1'b1; rw = 1'b1; end
      OP_JALR: begin
        dec.imm = imm_i; dec.f.branch_uc = 1'b1; dec.f.branch_rel = 1'b0; rw = 1'b1;
        ill = f3 != 3'd0;
      end
      OP_BRANCH: begin
        dec.imm = imm_b; dec.alu_ctl = br_f3(f3); dec.f.branch_c = 1'b1; dec.f.alu_src = 1'b0;
        ill = f3 == 3'd2 || f3 == 3'd3;
      end
      OP_LOAD: begin
        dec.imm = imm_i; dec.f.mem_read = 1'b1; rw = 1'b1;
        ill = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      OP_STORE: begin dec.imm = imm_s; dec.f.mem_write = 1'b1; ill = f3 > 3'd2; end
      OP_IMM: begin
        dec.imm = imm_i; rw = 1'b1;
        dec.alu_ctl = f3 == 3'd5 && f7 == 7'h20 ? ALU_SRA : alu_f3(f3);
        ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_REG: begin
        dec.f.alu_src = 1'b0; rw = 1'b1;
        if (f7 == 7'h01) begin
          dec.alu_ctl = alu_ctl_e'(5'd16 + 5'(f3)); dec.f.use_muldiv = 1'b1; ill = !EN_MULDIV;
        end else begin
          dec.alu_ctl = f7 == 7'h20 ? (f3 == 3'd0 ? ALU_SUB : ALU_SRA) : alu_f3(f3);
          ill = f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end
      end
      OP_FLW: begin dec.imm = imm_i; dec.f.mem_read = 1'b1; dec.f.writef = 1'b1; ill = !EN_FPU || f3 != 3'd2; end
      OP_FSW: begin dec.imm = imm_s; dec.f.mem_write = 1'b1; dec.f.readf2 = 1'b1; ill = !EN_FPU || f3 != 3'd2; end
      OP_FP: begin
        // FPU ops reuse the low codes: fadd 0, fsub 1, fmul 2, fdiv 4
        dec.alu_ctl = f7 == 7'h00 ? ALU_AND : f7 == 7'h04 ? ALU_OR : f7 == 7'h08 ? ALU_ADD : ALU_SLL;
        dec.f.alu_src = 1'b0; dec.f.readf1 = 1'b1; dec.f.readf2 = 1'b1; dec.f.writef = 1'b1; dec.f.use_fpu = 1'b1;
        ill = !EN_FPU || !(f7 == 7'h00 || f7 == 7'h04 || f7 == 7'h08 || f7 == 7'h0c);
      end
      OP_IN: begin dec.f.data_in = 1'b1; rw = 1'b1; end
      OP_OUT: dec.f.data_out = 1'b1;
      default: ill = 1'b1;
    endcase
    dec.f.reg_write = rw && instr[11:7] != 5'd0;
    if (ill) begin
      dec.imm = '0;
      dec.alu_ctl = ALU_ZERO;
      dec.f = '0;
      dec.f.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: RV32 decoder feeding a DEPTH-entry circular buffer of decoded instructions
module decode_pipe import decode_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int PC_W = 32,
  parameter bit EN_FPU = 1,
  parameter bit EN_MULDIV = 0
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  output logic in_ready,
  input logic [31:0] in_instr,
  input logic [PC_W-1:0] in_pc,
  input logic flush,
  output logic out_valid,
  input logic out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0] out_imm,
  output logic [4:0] out_alu_ctl,
  output logic [4:0] out_rs1,
  output logic [4:0] out_rs2,
  output logic [4:0] out_rd,
  output logic out_branch_uc,
  output logic out_branch_c,
  output logic out_branch_rel,
  output logic out_mem_read,
  output logic out_mem_write,
  output logic out_alu_pc,
  output logic out_alu_src,
  output logic out_reg_write,
  output logic out_data_out,
  output logic out_data_in,
  output logic out_readf1,
  output logic out_readf2,
  output logic out_writef,
  output logic out_use_fpu,
  output logic out_use_muldiv,
  output logic out_illegal
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  bundle_t dec, head;
  bundle_t mem_b [DEPTH];
  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [3:0] count;
  logic push, pop;
  flags_t fo;
  rv_decoder #(.EN_FPU(EN_FPU), .EN_MULDIV(EN_MULDIV)) u_dec (.instr(in_instr), .dec(dec));
  assign in_ready = count < 4'(DEPTH) && !rst;
  assign out_valid = count != 4'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      count <= count + 4'(push) - 4'(pop);
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_b[wp] <= dec;
      mem_pc[wp] <= in_pc;
    end
  end
  assign head = mem_b[rp];
  assign fo = out_valid ? head.f : '0;
  assign out_pc = mem_pc[rp];
  assign out_imm = head.imm;
  assign out_alu_ctl = head.alu_ctl;
  assign out_rs1 = head.rs1;
  assign out_rs2 = head.rs2;
  assign out_rd = head.rd;
  assign out_branch_uc = fo.branch_uc;
  assign out_branch_c = fo.branch_c;
  assign out_branch_rel = fo.branch_rel;
  assign out_mem_read = fo.mem_read;
  assign out_mem_write = fo.mem_write;
  assign out_alu_pc = fo.alu_pc;
  assign out_alu_src = fo.alu_src;
  assign out_reg_write = fo.reg_write;
  assign out_data_out = fo.data_out;
  assign out_data_in = fo.data_in;
  assign out_readf1 = fo.readf1;
  assign out_readf2 = fo.readf2;
  assign out_writef = fo.writef;
  assign out_use_fpu = fo.use_fpu;
  assign out_use_muldiv = fo.use_muldiv;
  assign out_illegal = fo.illegal;
endmodule
